// File: rtl/uart_loader_pkg.sv
// Shared constants for the serial memory loader: FSM state codes, sync marker, LEN decode.
// Latency: none (package only).
// Backpressure: n/a.
package uart_loader_pkg;

  // Frame parser states; plain constants keep the encoding visible in waveforms.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  // A LEN byte of zero encodes the largest frame rather than an empty one.
  localparam logic [8:0] LEN_ZERO_WORDS = 9'd256;

  function automatic logic [8:0] word_count(input logic [7:0] len);
    return (len == 8'd0) ? LEN_ZERO_WORDS : {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte watchdog: flags when no byte has arrived for TIMEOUT_CYCLES while a frame is open.
// Latency: expired is combinational from the counter; the parent registers the resulting err.
// Backpressure: none; clear restarts the count, run low holds it at zero.
module uart_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count idle cycles inside a frame; any received byte or leaving the frame restarts it.
  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/uart_loader.sv
// Serial frame loader: SYNC/ADDR/LEN/DATA/CSUM byte stream -> 32-bit word writes; optional watchdog under UART_LOADER_TIMEOUT_EN.
// Latency: wr_valid one cycle after the 4th byte of a word; done/err one cycle after the CSUM byte.
// Backpressure: one-word buffer toward the sink; none toward the receiver, so a word finishing onto a stalled buffer aborts the frame.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  logic [2:0]  state;
  logic [1:0]  byte_idx;    // position within the ADDR field or the current data word
  logic [8:0]  words_left;
  logic [7:0]  csum;
  logic [23:0] word_lo;     // first three bytes of the word being assembled
  logic [31:0] next_addr;   // address the next completed word will be written to
  logic        timeout;

`ifdef UART_LOADER_TIMEOUT_EN
  uart_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .run     (busy),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  // Frame parser plus single-word write buffer; a retiring write and a new word may share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_idx   <= '0;
      words_left <= '0;
      csum       <= '0;
      word_lo    <= '0;
      next_addr  <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end

      if (timeout) begin
        // The pending write, if any, is left to drain on its own.
        state <= ST_IDLE;
        err   <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= ST_ADDR;
              byte_idx <= '0;
              csum     <= '0;
            end
          end
          ST_ADDR: begin
            csum      <= csum ^ rx_data;
            next_addr <= {next_addr[23:0], rx_data};
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            csum       <= csum ^ rx_data;
            words_left <= word_count(rx_data);
            state      <= ST_DATA;
          end
          ST_DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_lo[7:0]   <= rx_data;
              2'd1:    word_lo[15:8]  <= rx_data;
              2'd2:    word_lo[23:16] <= rx_data;
              default: begin
                if (wr_valid && !wr_ready) begin
                  // Buffer still owned by the previous word: drop this one and abandon the frame.
                  err   <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  wr_valid   <= 1'b1;
                  wr_addr    <= next_addr;
                  wr_data    <= {rx_data, word_lo};
                  next_addr  <= next_addr + 32'd4;
                  words_left <= words_left - 9'd1;
                  if (words_left == 9'd1) begin
                    state <= ST_CSUM;
                  end
                end
              end
            endcase
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (rx_data == csum) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frames built from byte lists, expected writes/events queued at send time.
// Latency model: write visible the cycle after its 4th byte, done/err the cycle after CSUM.
// Backpressure: wr_ready driven always-high, random, or held low to provoke overflow.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  uart_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  localparam int K_NONE  = 0;
  localparam int K_SYNC  = 1;
  localparam int K_WEND  = 2;
  localparam int K_CGOOD = 3;
  localparam int K_CBAD  = 4;
  localparam int K_TMO   = 5;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [1:0]  code;
    int unsigned cyc;
  } evt_t;

  wr_t         exp_wr[$];
  evt_t        exp_evt[$];
  logic [31:0] fixed_q[$];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          m_pending = 1'b0;
  bit          m_busy = 1'b0;
  bit          mon_en = 1'b0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: compares DUT outputs against the model state and the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("busy", busy, m_busy);
      check("wr_valid", wr_valid, m_pending);
      if (wr_valid) begin
        check("wr_queued", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          check("wr_addr", wr_addr, exp_wr[0].a);
          check("wr_data", wr_data, exp_wr[0].d);
          if (wr_ready) void'(exp_wr.pop_front());
        end
      end
      if (done || err || (exp_evt.size() != 0 && exp_evt[0].cyc <= cyc)) begin
        check("evt_queued", exp_evt.size() != 0, 1);
        if (exp_evt.size() != 0) begin
          evt_t e;
          e = exp_evt.pop_front();
          check("evt_kind", {done, err}, e.code);
          check("evt_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One clock cycle of stimulus; predicts buffer occupancy, busy and events for the coming edge.
  task automatic step(input bit v, input logic [7:0] d, input int kind,
                      input logic [31:0] wa, input logic [31:0] wd, output bit abort);
    bit hs, nxt_pending, nxt_busy;
    abort    = 1'b0;
    rx_valid = v;
    rx_data  = d;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = 1'b0;
    endcase
    hs          = m_pending && wr_ready;
    nxt_pending = m_pending && !hs;
    nxt_busy    = m_busy;
    if (kind == K_TMO) begin
      exp_evt.push_back(evt_t'{EV_ERR, cyc + 1});
      nxt_busy = 1'b0;
    end else if (v) begin
      case (kind)
        K_SYNC: nxt_busy = 1'b1;
        K_WEND: begin
          if (m_pending && !hs) begin
            exp_evt.push_back(evt_t'{EV_ERR, cyc + 1});
            nxt_busy = 1'b0;
            abort    = 1'b1;
          end else begin
            exp_wr.push_back(wr_t'{wa, wd});
            nxt_pending = 1'b1;
          end
        end
        K_CGOOD: begin
          exp_evt.push_back(evt_t'{EV_DONE, cyc + 1});
          nxt_busy = 1'b0;
        end
        K_CBAD: begin
          exp_evt.push_back(evt_t'{EV_ERR, cyc + 1});
          nxt_busy = 1'b0;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    m_pending = nxt_pending;
    m_busy    = nxt_busy;
    #1;
  endtask

  task automatic idle(input int n);
    bit ab;
    repeat (n) step(1'b0, 8'h00, K_NONE, 32'h0, 32'h0, ab);
  endtask

  task automatic do_reset(input int n);
    mon_en   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wr_ready = 1'b0;
    rst      = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    exp_wr.delete();
    exp_evt.delete();
    m_pending = 1'b0;
    m_busy    = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends SYNC + body + CSUM. cut_at stops before that body byte; stall_at inserts stall_len idle cycles.
  task automatic send_frame(input logic [31:0] a, input logic [7:0] len, input bit bad,
                            input int max_gap, input int cut_at, input int stall_at,
                            input int stall_len);
    logic [7:0]  b[$];
    logic [7:0]  cs;
    logic [31:0] w;
    int          nw;
    bit          ab;
    nw = (len == 8'd0) ? 256 : int'(len);
    b.push_back(a[31:24]);
    b.push_back(a[23:16]);
    b.push_back(a[15:8]);
    b.push_back(a[7:0]);
    b.push_back(len);
    for (int i = 0; i < nw; i++) begin
      if (fixed_q.size() != 0) w = fixed_q.pop_front();
      else w = $urandom;
      for (int k = 0; k < 4; k++) b.push_back(w[8*k +: 8]);
    end
    cs = 8'h00;
    foreach (b[i]) cs ^= b[i];
    step(1'b1, 8'h55, K_SYNC, 32'h0, 32'h0, ab);
    for (int i = 0; i < b.size(); i++) begin
      int j;
      if (i == cut_at) return;
      if (i == stall_at) idle(stall_len);
      else if (max_gap > 0) idle($urandom_range(0, max_gap));
      j = i - 5;
      if (j >= 0 && (j % 4) == 3) begin
        step(1'b1, b[i], K_WEND, a + 32'(4 * (j / 4)), {b[i], b[i-1], b[i-2], b[i-3]}, ab);
        if (ab) return;
      end else begin
        step(1'b1, b[i], K_NONE, 32'h0, 32'h0, ab);
      end
    end
    if (max_gap > 0) idle($urandom_range(0, max_gap));
    step(1'b1, bad ? ~cs : cs, bad ? K_CBAD : K_CGOOD, 32'h0, 32'h0, ab);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ab;
    logic [7:0]  g;
    rdy_mode = 0;
    do_reset(3);

    // Directed frame: one word 0x44332211 at 0x1000, good checksum.
    fixed_q.push_back(32'h4433_2211);
    send_frame(32'h0000_1000, 8'd1, 1'b0, 0, -1, -1, 0);
    idle(3);

    // Same frame, corrupted checksum: write still lands, err instead of done.
    fixed_q.push_back(32'h4433_2211);
    send_frame(32'h0000_1000, 8'd1, 1'b1, 0, -1, -1, 0);
    idle(3);

    // Address wraps past 0xFFFFFFFC.
    send_frame(32'hFFFF_FFFC, 8'd2, 1'b0, 0, -1, -1, 0);
    idle(3);

    // Sink stalled, bytes back-to-back: second word overflows, first word is held and later retired.
    rdy_mode = 2;
    send_frame(32'h0000_2000, 8'd2, 1'b0, 0, -1, -1, 0);
    idle(5);
    rdy_mode = 0;
    idle(3);

    // Garbage before SYNC, reset mid-DATA, then a clean frame.
    step(1'b1, 8'h00, K_NONE, 32'h0, 32'h0, ab);
    step(1'b1, 8'hAA, K_NONE, 32'h0, 32'h0, ab);
    send_frame(32'h0000_3000, 8'd3, 1'b0, 0, 11, -1, 0);
    do_reset(1);
    send_frame(32'h0000_4000, 8'd2, 1'b0, 0, -1, -1, 0);
    idle(3);

`ifdef UART_LOADER_TIMEOUT_EN
    // SYNC plus two address bytes, then silence: watchdog fires after 100 idle cycles.
    step(1'b1, 8'h55, K_SYNC, 32'h0, 32'h0, ab);
    step(1'b1, 8'h12, K_NONE, 32'h0, 32'h0, ab);
    step(1'b1, 8'h34, K_NONE, 32'h0, 32'h0, ab);
    idle(99);
    step(1'b0, 8'h00, K_TMO, 32'h0, 32'h0, ab);
    idle(3);
`else
    // Long silence mid-address is tolerated; the frame completes normally afterwards.
    send_frame(32'h0000_5000, 8'd1, 1'b0, 0, -1, 2, 150);
    idle(3);
`endif

    // Randomized frames: random address, length, gaps, sink stalls and checksum corruption.
    for (int f = 0; f < 40; f++) begin
      rdy_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'h55) g = 8'h54;
        step(1'b1, g, K_NONE, 32'h0, 32'h0, ab);
      end
      send_frame($urandom & 32'hFFFF_FFFC, 8'($urandom_range(1, 6)),
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 3), -1, -1, 0);
      idle(2);
    end

    // LEN=0 encodes 256 words.
    rdy_mode = 0;
    send_frame(32'h0001_0000, 8'd0, 1'b0, 0, -1, -1, 0);

    rdy_mode = 0;
    idle(10);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("evt_queue_drained", exp_evt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
